tron_game_ctrl: RTL and testbench

Round/game sequencer for the two-player light-cycle datapath. Runs the IDLE → COUNTDOWN → RUN → ROUND_END → GAME_OVER flow and drives the drawing block's `dflt` (reload start positions, clear traces) and per-step `advance` enable. It also latches validated player directions and keeps score from the crash flags returned by the collision logic. It sits between the input/button logic and the `draw_object` datapath, and is clocked by the pixel clock.

---
 rtl/tron_game_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_tron_game_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tron_game_ctrl.sv
// Round/game sequencer for the two-player light-cycle datapath: countdown, stepping,
// direction filtering, crash scoring and game-over handling. All outputs registered.
module tron_game_ctrl #(
    parameter int SPEED_DIV        = 2,
    parameter int COUNTDOWN_FRAMES = 60,
    parameter int ROUND_HOLD       = 120,
    parameter int WIN_SCORE        = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       frame_end,
    input  logic       start,
    input  logic [2:0] p1_req,
    input  logic [2:0] p2_req,
    input  logic       p1_crash,
    input  logic       p2_crash,
    output logic [2:0] p1_info,
    output logic [2:0] p2_info,
    output logic       dflt,
    output logic       advance,
    output logic [2:0] state,
    output logic [1:0] winner,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_RUN       = 3'd2,
        S_ROUND_END = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    // Direction encoding: UP=0, DOWN=1, LEFT=2, RIGHT=3, STOP=4, 5..7 unused.
    localparam logic [2:0] DIR_RIGHT = 3'd3;
    localparam logic [2:0] DIR_LEFT  = 3'd2;

    localparam logic [7:0] SPEED_LAST = 8'(SPEED_DIV);
    localparam logic [7:0] CD_LAST    = 8'(COUNTDOWN_FRAMES);
    localparam logic [7:0] HOLD_LAST  = 8'(ROUND_HOLD);
    localparam logic [3:0] WIN_LIMIT  = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] p1_info_q, p1_info_d, p2_info_q, p2_info_d;
    logic [2:0] p1_pend_q, p1_pend_d, p2_pend_q, p2_pend_d;
    logic       dflt_q, dflt_d, advance_q, advance_d;
    logic [1:0] winner_q, winner_d;
    logic [3:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic [7:0] cnt_inc;

    // Accept only the four moving directions, and never a direct reversal.
    function automatic logic dir_ok(input logic [2:0] req, input logic [2:0] info);
        return (req[2] == 1'b0) && !((req[2:1] == info[2:1]) && (req[0] != info[0]));
    endfunction

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p1_info_d  = p1_info_q;
        p2_info_d  = p2_info_q;
        p1_pend_d  = p1_pend_q;
        p2_pend_d  = p2_pend_q;
        winner_d   = winner_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        advance_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COUNTDOWN;
                    cnt_d   = 8'd0;
                end
            end

            S_COUNTDOWN: begin
                p1_info_d = DIR_RIGHT;
                p2_info_d = DIR_LEFT;
                p1_pend_d = DIR_RIGHT;
                p2_pend_d = DIR_LEFT;
                winner_d  = 2'd0;
                if (frame_end) begin
                    if (cnt_inc == CD_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            S_RUN: begin
                if (dir_ok(p1_req, p1_info_q)) p1_pend_d = p1_req;
                if (dir_ok(p2_req, p2_info_q)) p2_pend_d = p2_req;
                if (frame_end) begin
                    // Crashes take priority: the step for this frame is dropped.
                    if (p1_crash || p2_crash) begin
                        state_d = S_ROUND_END;
                        cnt_d   = 8'd0;
                        if (p1_crash && p2_crash) begin
                            winner_d = 2'd3;
                        end else if (p1_crash) begin
                            winner_d = 2'd2;
                            if (p2_score_q != 4'hF) p2_score_d = p2_score_q + 4'd1;
                        end else begin
                            winner_d = 2'd1;
                            if (p1_score_q != 4'hF) p1_score_d = p1_score_q + 4'd1;
                        end
                    end else if (cnt_inc == SPEED_LAST) begin
                        cnt_d     = 8'd0;
                        advance_d = 1'b1;
                        p1_info_d = p1_pend_d;
                        p2_info_d = p2_pend_d;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            S_ROUND_END: begin
                if (frame_end) begin
                    if (cnt_inc == HOLD_LAST) begin
                        cnt_d = 8'd0;
                        if (p1_score_q >= WIN_LIMIT || p2_score_q >= WIN_LIMIT)
                            state_d = S_GAME_OVER;
                        else
                            state_d = S_COUNTDOWN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            S_GAME_OVER: begin
                if (start) begin
                    state_d    = S_COUNTDOWN;
                    cnt_d      = 8'd0;
                    p1_score_d = 4'd0;
                    p2_score_d = 4'd0;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Traces stay frozen on screen after a crash and at game over.
        dflt_d = (state_d == S_IDLE) || (state_d == S_COUNTDOWN);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            p1_info_q  <= DIR_RIGHT;
            p2_info_q  <= DIR_LEFT;
            p1_pend_q  <= DIR_RIGHT;
            p2_pend_q  <= DIR_LEFT;
            dflt_q     <= 1'b1;
            advance_q  <= 1'b0;
            winner_q   <= 2'd0;
            p1_score_q <= 4'd0;
            p2_score_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p1_info_q  <= p1_info_d;
            p2_info_q  <= p2_info_d;
            p1_pend_q  <= p1_pend_d;
            p2_pend_q  <= p2_pend_d;
            dflt_q     <= dflt_d;
            advance_q  <= advance_d;
            winner_q   <= winner_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
        end
    end

    assign state    = state_q;
    assign p1_info  = p1_info_q;
    assign p2_info  = p2_info_q;
    assign dflt     = dflt_q;
    assign advance  = advance_q;
    assign winner   = winner_q;
    assign p1_score = p1_score_q;
    assign p2_score = p2_score_q;

endmodule

// File: tb/tb_tron_game_ctrl.sv
// Directed bench for tron_game_ctrl: countdown, stepping, direction filter,
// scoring, game over and asynchronous reset.
module tb_tron_game_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       frame_end, start;
    logic [2:0] p1_req, p2_req;
    logic       p1_crash, p2_crash;
    logic [2:0] p1_info, p2_info;
    logic       dflt, advance;
    logic [2:0] state;
    logic [1:0] winner;
    logic [3:0] p1_score, p2_score;

    int checks = 0;
    int errors = 0;

    tron_game_ctrl dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .frame_end(frame_end),
        .start    (start),
        .p1_req   (p1_req),
        .p2_req   (p2_req),
        .p1_crash (p1_crash),
        .p2_crash (p2_crash),
        .p1_info  (p1_info),
        .p2_info  (p2_info),
        .dflt     (dflt),
        .advance  (advance),
        .state    (state),
        .winner   (winner),
        .p1_score (p1_score),
        .p2_score (p2_score)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame_end pulse; returns on the negedge after the sampling edge.
    task automatic frame(input logic c1, input logic c2);
        @(negedge clock);
        frame_end = 1'b1;
        p1_crash  = c1;
        p2_crash  = c2;
        @(negedge clock);
        frame_end = 1'b0;
        p1_crash  = 1'b0;
        p2_crash  = 1'b0;
    endtask

    task automatic pulse_start(input logic with_frame);
        @(negedge clock);
        start     = 1'b1;
        frame_end = with_frame;
        @(negedge clock);
        start     = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic set_req(input logic [2:0] r1, input logic [2:0] r2);
        @(negedge clock);
        p1_req = r1;
        p2_req = r2;
    endtask

    // From COUNTDOWN with a cleared counter: count down, crash, hold.
    task automatic play_round(input logic c1, input logic c2);
        repeat (60) frame(1'b0, 1'b0);
        frame(c1, c2);
        repeat (120) frame(1'b0, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b0;
        frame_end = 1'b0;
        start     = 1'b0;
        p1_req    = 3'd4;
        p2_req    = 3'd4;
        p1_crash  = 1'b0;
        p2_crash  = 1'b0;
        repeat (2) @(negedge clock);

        chk("reset_state", state, 0);
        chk("reset_dflt", dflt, 1);
        chk("reset_advance", advance, 0);
        chk("reset_p1_info", p1_info, 3);
        chk("reset_p2_info", p2_info, 2);
        chk("reset_winner", winner, 0);
        chk("reset_scores", {p1_score, p2_score}, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // start together with frame_end: that frame must not count
        pulse_start(1'b1);
        chk("start_to_countdown", state, 1);
        repeat (59) frame(1'b0, 1'b0);
        chk("countdown_frame59_state", state, 1);
        chk("countdown_frame59_dflt", dflt, 1);
        frame(1'b0, 1'b0);
        chk("countdown_done_state", state, 2);
        chk("run_dflt_low", dflt, 0);
        chk("run_entry_no_advance", advance, 0);

        frame(1'b0, 1'b0);
        chk("frame61_no_advance", advance, 0);
        frame(1'b0, 1'b0);
        chk("frame62_advance", advance, 1);
        chk("first_step_p1_info", p1_info, 3);
        chk("first_step_p2_info", p2_info, 2);
        @(negedge clock);
        chk("advance_one_cycle", advance, 0);

        // P1 reversal ignored, then UP overwritten by DOWN; P2 turns UP
        set_req(3'd2, 3'd4);
        set_req(3'd0, 3'd0);
        set_req(3'd1, 3'd4);
        set_req(3'd4, 3'd4);
        frame(1'b0, 1'b0);
        chk("frame63_no_advance", advance, 0);
        frame(1'b0, 1'b0);
        chk("step2_advance", advance, 1);
        chk("step2_p1_down", p1_info, 1);
        chk("step2_p2_up", p2_info, 0);

        // STOP and a reversal (UP while DOWN) both leave P1 unchanged
        set_req(3'd0, 3'd5);
        set_req(3'd4, 3'd4);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        chk("step3_advance", advance, 1);
        chk("step3_p1_kept", p1_info, 1);
        chk("step3_p2_kept", p2_info, 0);

        pulse_start(1'b0);
        chk("start_ignored_in_run", state, 2);

        // P2 crashes on the frame that would otherwise step
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b1);
        chk("crash_advance_suppressed", advance, 0);
        chk("crash_state", state, 3);
        chk("crash_winner_p1", winner, 1);
        chk("crash_p1_score", p1_score, 1);
        chk("crash_p2_score", p2_score, 0);
        chk("round_end_dflt", dflt, 0);
        repeat (119) frame(1'b0, 1'b0);
        chk("hold119_state", state, 3);
        frame(1'b0, 1'b0);
        chk("hold_done_state", state, 1);
        chk("hold_done_dflt", dflt, 1);
        @(negedge clock);
        chk("countdown_winner_clear", winner, 0);
        chk("countdown_p1_forced", p1_info, 3);
        chk("countdown_p2_forced", p2_info, 2);

        // Both crash: draw, no score change
        repeat (60) frame(1'b0, 1'b0);
        chk("round2_run", state, 2);
        frame(1'b1, 1'b1);
        chk("draw_winner", winner, 3);
        chk("draw_scores", {p1_score, p2_score}, {4'd1, 4'd0});
        chk("draw_state", state, 3);
        repeat (120) frame(1'b0, 1'b0);
        chk("draw_to_countdown", state, 1);

        // P1 reaches WIN_SCORE
        play_round(1'b0, 1'b1);
        chk("p1_score_2", p1_score, 2);
        chk("not_over_yet", state, 1);
        play_round(1'b0, 1'b1);
        chk("game_over_state", state, 4);
        chk("game_over_p1_score", p1_score, 3);
        repeat (5) frame(1'b0, 1'b0);
        chk("game_over_held_state", state, 4);
        chk("game_over_held_score", p1_score, 3);
        chk("game_over_held_winner", winner, 1);
        pulse_start(1'b0);
        chk("restart_state", state, 1);
        chk("restart_scores", {p1_score, p2_score}, 0);

        // Build up scores 2/1, then reset mid-RUN
        play_round(1'b0, 1'b1);
        play_round(1'b1, 1'b0);
        chk("p2_round_winner", winner, 2);
        chk("p2_score_1", p2_score, 1);
        play_round(1'b0, 1'b1);
        repeat (60) frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        chk("pre_reset_state", state, 2);
        chk("pre_reset_scores", {p1_score, p2_score}, {4'd2, 4'd1});
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_state", state, 0);
        chk("async_reset_scores", {p1_score, p2_score}, 0);
        chk("async_reset_dflt", dflt, 1);
        chk("async_reset_p1_info", p1_info, 3);
        @(negedge clock);
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
